// File: rtl/step1_seq_ctrl.sv
// Frame sequencer for the step-1 butterfly stage: turns a start-of-frame pulse into per-beat controls.
// Optional statistics counters are built when STEP1_SEQ_STATS_EN is defined.
module step1_seq_ctrl #(
  parameter int unsigned FRAME_LEN    = 32,
  parameter int unsigned DIRECT_BEATS = 2,
  parameter int unsigned BF_DLY       = 3,
  parameter int unsigned BF_LAT       = 1,
  localparam int unsigned CNT_W       = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_sof,
  output logic             sr_shift_en,
  output logic             src_sel,
  output logic [CNT_W-1:0] beat_idx,
  output logic             bf_valid,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             sof_err,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int unsigned DLY_W = BF_DLY + BF_LAT;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             sr_nxt, src_nxt, err_nxt, busy_nxt;
  logic [CNT_W-1:0] beat_nxt;
  // Per-beat valid and last-beat flag travel together so overlapping frames stay independent
  logic [DLY_W-1:0] vld_line, vld_nxt, last_line, last_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      sr_shift_en <= 1'b0;
      beat_idx    <= '0;
      src_sel     <= 1'b0;
      sof_err     <= 1'b0;
      busy        <= 1'b0;
      vld_line    <= '0;
      last_line   <= '0;
    end else begin
      state       <= state_nxt;
      sr_shift_en <= sr_nxt;
      beat_idx    <= beat_nxt;
      src_sel     <= src_nxt;
      sof_err     <= err_nxt;
      busy        <= busy_nxt;
      vld_line    <= vld_nxt;
      last_line   <= last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = 1'b0;
    beat_nxt    = '0;
    err_nxt     = 1'b0;
    vld_nxt[0]  = sr_shift_en;
    last_nxt[0] = sr_shift_en && (beat_idx == LAST_BEAT);
    for (int unsigned i = 1; i < DLY_W; i++) begin
      vld_nxt[i]  = vld_line[i-1];
      last_nxt[i] = last_line[i-1];
    end

    case (state)
      IDLE: begin
        if (din_sof) begin
          state_nxt = RUN;
          sr_nxt    = 1'b1;
        end
      end
      RUN: begin
        if (beat_idx == LAST_BEAT) begin
          // Start on the last beat chains the next frame with no gap
          if (din_sof) sr_nxt = 1'b1;
          else         state_nxt = DRAIN;
        end else begin
          sr_nxt   = 1'b1;
          beat_nxt = beat_idx + CNT_W'(1);
          err_nxt  = din_sof;
        end
      end
      DRAIN: begin
        if (din_sof) begin
          state_nxt = RUN;
          sr_nxt    = 1'b1;
        end else if (~|vld_nxt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    src_nxt  = sr_nxt && (beat_nxt >= CNT_W'(DIRECT_BEATS));
    busy_nxt = sr_nxt | (|vld_nxt);
  end

  assign bf_valid   = vld_line[BF_DLY-1];
  assign dout_valid = vld_line[DLY_W-1];
  assign frame_done = last_line[DLY_W-1];

`ifdef STEP1_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (sof_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_step1_seq_ctrl.sv
// Self-checking bench for step1_seq_ctrl: expected per-cycle outputs are derived from frame timing
// and queued as stimulus is driven, then popped and compared after each clock edge.
module tb_step1_seq_ctrl;

  localparam int FL   = 32;
  localparam int DB   = 2;
  localparam int BD   = 3;
  localparam int BL   = 1;
  localparam int MAXC = 512;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       din_sof = 1'b0;
  logic       sr_shift_en, src_sel, bf_valid, dout_valid, frame_done, busy, sof_err;
  logic [4:0] beat_idx;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  step1_seq_ctrl #(.FRAME_LEN(FL), .DIRECT_BEATS(DB), .BF_DLY(BD), .BF_LAT(BL)) dut (
    .clk(clk), .rstn(rstn), .din_sof(din_sof),
    .sr_shift_en(sr_shift_en), .src_sel(src_sel), .beat_idx(beat_idx),
    .bf_valid(bf_valid), .dout_valid(dout_valid), .frame_done(frame_done),
    .busy(busy), .sof_err(sof_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sr;
    logic [4:0] beat;
    logic       src;
    logic       bf;
    logic       dv;
    logic       fd;
    logic       busy;
    logic       err;
    logic [15:0] fc;
    logic [7:0]  ec;
  } obs_t;

  obs_t sb_q[$];
  obs_t exp_tab[MAXC];
  bit   sof_at[MAXC];
  int   n_assert = 0;
  int   n_fail = 0;
  int   exp_fc = 0;
  int   exp_ec = 0;

`ifdef STEP1_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic obs_t sample();
    obs_t o;
    o.sr = sr_shift_en; o.beat = beat_idx; o.src = src_sel; o.bf = bf_valid;
    o.dv = dout_valid; o.fd = frame_done; o.busy = busy; o.err = sof_err;
    o.fc = frame_cnt; o.ec = err_cnt;
    return o;
  endfunction

  task automatic check(input string tag, input int cyc);
    obs_t e, g;
    e = sb_q.pop_front();
    g = sample();
    n_assert++;
    assert (g === e) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, g, e);
    end
  endtask

  // Expected outputs: cycle c is the interval after edge c-1; a start sampled at edge s owns cycles s+1..s+FL
  task automatic build_model(input int ncyc);
    int last_s;
    for (int c = 0; c < MAXC; c++) exp_tab[c] = '0;
    last_s = -1000;
    for (int e = 0; e < ncyc; e++) begin
      if (sof_at[e]) begin
        if (e >= last_s + FL) begin
          last_s = e;
          for (int k = 0; k < FL; k++) begin
            int c;
            c = e + 1 + k;
            exp_tab[c].sr   = 1'b1;
            exp_tab[c].beat = 5'(k);
            exp_tab[c].src  = (k >= DB);
            exp_tab[c+BD].bf = 1'b1;
            exp_tab[c+BD+BL].dv = 1'b1;
            for (int b = 0; b <= BD + BL; b++) exp_tab[c+b].busy = 1'b1;
          end
          exp_tab[e+FL+BD+BL].fd = 1'b1;
        end else begin
          exp_tab[e+1].err = 1'b1;
        end
      end
    end
  endtask

  task automatic run_scn(input string tag, input int ncyc);
    obs_t e;
    build_model(ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      din_sof = sof_at[c-1];
      e = exp_tab[c];
      e.fc = STATS ? 16'(exp_fc) : 16'd0;
      e.ec = STATS ? 8'(exp_ec) : 8'd0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check(tag, c);
      if (exp_tab[c].fd) exp_fc++;
      if (exp_tab[c].err && exp_ec < 255) exp_ec++;
      @(negedge clk);
    end
    din_sof = 1'b0;
    for (int i = 0; i < MAXC; i++) sof_at[i] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    sb_q.push_back('0);
    check(tag, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rstn = 1'b1;

    sof_at[0] = 1'b1;
    run_scn("single", 40);

    sof_at[0] = 1'b1; sof_at[32] = 1'b1;
    run_scn("back2back", 72);

    sof_at[0] = 1'b1; sof_at[10] = 1'b1;
    run_scn("overlap", 40);

    sof_at[0] = 1'b1; sof_at[34] = 1'b1;
    run_scn("drain_start", 74);

    // Abort a frame with reset, then restart on the first edge after release
    sof_at[0] = 1'b1;
    run_scn("pre_reset", 15);
    rstn = 1'b0;
    #1;
    exp_fc = 0;
    exp_ec = 0;
    check_zero("reset_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    rstn = 1'b1;
    sof_at[0] = 1'b1;
    run_scn("post_reset", 40);

    // Held start: one accepted start per FL edges, all others ignored
    for (int i = 0; i < 330; i++) sof_at[i] = 1'b1;
    run_scn("saturate", 370);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
